// File: rtl/video_pkg.sv
// Shared definitions for the video pipeline blocks.
//   POL_HIGH / POL_LOW : sync polarity selectors for VS_POL / HS_POL parameters
//   DEF_XW/YW/DW       : default coordinate and pixel widths
//   sync_t             : {hs, vs, de} bundle carried alongside pixel data
package video_pkg;
    localparam int POL_LOW  = 0;
    localparam int POL_HIGH = 1;

    localparam int DEF_XW = 12;
    localparam int DEF_YW = 12;
    localparam int DEF_DW = 24;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;
endpackage

// File: rtl/video_pos_gen_if.sv
// Video position tagger bus: raw sync/data in, delayed sync/data plus
// coordinate tags and stream measurements out.
//   master : stream source / consumer side (drives i_*, receives o_* and tags)
//   slave  : video_pos_gen side
interface video_pos_gen_if
    import video_pkg::*;
#(
    parameter int XW  = DEF_XW,
    parameter int YW  = DEF_YW,
    parameter int DW  = DEF_DW,
    parameter int FCW = 16
);
    logic          i_hs;
    logic          i_vs;
    logic          i_de;
    logic [DW-1:0] i_data;

    logic           o_hs;
    logic           o_vs;
    logic           o_de;
    logic [DW-1:0]  o_data;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           o_sof;
    logic           o_eol;
    logic [XW-1:0]  o_width;
    logic [YW-1:0]  o_height;
    logic [FCW-1:0] o_frame_cnt;
    logic           o_meas_valid;

    modport master (
        output i_hs, i_vs, i_de, i_data,
        input  o_hs, o_vs, o_de, o_data, x, y, o_sof, o_eol,
               o_width, o_height, o_frame_cnt, o_meas_valid
    );

    modport slave (
        input  i_hs, i_vs, i_de, i_data,
        output o_hs, o_vs, o_de, o_data, x, y, o_sof, o_eol,
               o_width, o_height, o_frame_cnt, o_meas_valid
    );
endinterface

// File: rtl/video_delay_line.sv
// STAGES-deep shift register for the sync bundle plus an opaque payload
// (data, tags, measurements). The end-of-line flag is produced while loading
// the final stage: the word entering it has de=1 and the word one step
// younger has de=0. For STAGES=1 that younger word is still at the block
// input, hence the la_de lookahead port.
//   clk, rst_n : clock, async active-low reset
//   la_de      : de of the sample one stage younger than sync_in
//   sync_in    : sync bundle entering stage 0 ; sync_out : final stage
//   pay_in     : payload entering stage 0     ; pay_out  : final stage
//   eol        : last-pixel flag aligned with sync_out/pay_out
module video_delay_line
    import video_pkg::*;
#(
    parameter int    STAGES   = 1,
    parameter int    PW       = 1,
    parameter sync_t SYNC_RST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          la_de,
    input  sync_t         sync_in,
    input  logic [PW-1:0] pay_in,
    output sync_t         sync_out,
    output logic [PW-1:0] pay_out,
    output logic          eol
);
    sync_t         sync_q [STAGES];
    logic [PW-1:0] pay_q  [STAGES];
    logic          eol_q;

    // de_tap[k] = de of the word k stages behind the raw input
    logic [STAGES:0] de_tap;
    assign de_tap[0] = la_de;
    assign de_tap[1] = sync_in.de;
    for (genvar k = 2; k <= STAGES; k++) begin : g_tap
        assign de_tap[k] = sync_q[k-2].de;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < STAGES; j++) begin
                sync_q[j] <= SYNC_RST;
                pay_q[j]  <= '0;
            end
            eol_q <= 1'b0;
        end else begin
            sync_q[0] <= sync_in;
            pay_q[0]  <= pay_in;
            for (int j = 1; j < STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
                pay_q[j]  <= pay_q[j-1];
            end
            eol_q <= de_tap[STAGES] & ~de_tap[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign pay_out  = pay_q[STAGES-1];
    assign eol      = eol_q;
endmodule

// File: rtl/video_pos_gen.sv
// Video timing/position tagger. Registers the raw stream once (stage 1),
// derives X/Y/SOF tags and width/height/frame measurements there, and
// carries everything through a DLY-1 stage delay line so all outputs sit
// exactly DLY cycles behind the inputs.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : video_pos_gen_if.slave (i_hs/i_vs/i_de/i_data in;
//                o_* sync/data, x, y, o_sof, o_eol and measurements out)
// DLY legal range is 2..8.
module video_pos_gen
    import video_pkg::*;
#(
    parameter int XW     = DEF_XW,
    parameter int YW     = DEF_YW,
    parameter int DW     = DEF_DW,
    parameter int DLY    = 2,
    parameter int VS_POL = POL_HIGH,
    parameter int HS_POL = POL_HIGH,
    parameter int FCW    = 16
) (
    input logic            clk,
    input logic            rst_n,
    video_pos_gen_if.slave bus
);
    localparam logic  VS_ACT    = (VS_POL == POL_HIGH);
    localparam logic  HS_IDLE   = (HS_POL != POL_HIGH);
    localparam sync_t SYNC_IDLE = '{hs: HS_IDLE, vs: ~VS_ACT, de: 1'b0};
    localparam int    PW        = 2*XW + 2*YW + DW + FCW + 2;

    function automatic logic [XW-1:0] inc_x(input logic [XW-1:0] v);
        return (&v) ? v : v + XW'(1);
    endfunction

    function automatic logic [YW-1:0] inc_y(input logic [YW-1:0] v);
        return (&v) ? v : v + YW'(1);
    endfunction

    sync_t          s1_sync, sync_out;
    logic [DW-1:0]  s1_data;
    logic           s1_vsa, vsa_d, de_d;
    logic [XW-1:0]  x_prev, x_tag, width_q, width_nx;
    logic [YW-1:0]  y_cnt, y_tag, y_nx, lines, height_q, height_nx;
    logic [FCW-1:0] fcnt_q, fcnt_nx;
    logic           seen_vs, mv_q, mv_nx, sof_tag, vs_edge, de_fall;
    logic [PW-1:0]  pay_in, pay_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sync  <= SYNC_IDLE;
            s1_data  <= '0;
            s1_vsa   <= 1'b0;
            vsa_d    <= 1'b0;
            de_d     <= 1'b0;
            x_prev   <= '0;
            y_cnt    <= '0;
            seen_vs  <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            fcnt_q   <= '0;
            mv_q     <= 1'b0;
        end else begin
            s1_sync  <= '{hs: bus.i_hs, vs: bus.i_vs, de: bus.i_de};
            s1_data  <= bus.i_data;
            s1_vsa   <= ~(bus.i_vs ^ VS_ACT);
            vsa_d    <= s1_vsa;
            de_d     <= s1_sync.de;
            x_prev   <= x_tag;
            y_cnt    <= y_nx;
            seen_vs  <= seen_vs | vs_edge;
            width_q  <= width_nx;
            height_q <= height_nx;
            fcnt_q   <= fcnt_nx;
            mv_q     <= mv_nx;
        end
    end

    assign vs_edge = s1_vsa & ~vsa_d;
    assign de_fall = de_d & ~s1_sync.de;

    // x restarts on DE rise and is forced to 0 outside DE
    assign x_tag = (s1_sync.de && de_d) ? inc_x(x_prev) : '0;

    // lines closed since the last VS edge, including one ending this cycle,
    // so a DE fall coincident with the VS edge still counts toward height
    assign lines = de_fall ? inc_y(y_cnt) : y_cnt;
    assign y_tag = vs_edge ? '0 : y_cnt;
    assign y_nx  = vs_edge ? '0 : lines;

    // seen_vs gates both SOF and the height latch so that whatever partial
    // frame precedes the first VS edge after reset is ignored
    assign sof_tag   = s1_sync.de && x_tag == '0 && y_tag == '0 && (seen_vs || vs_edge);
    assign width_nx  = de_fall ? inc_x(x_prev) : width_q;
    assign height_nx = (vs_edge && seen_vs && lines != '0) ? lines : height_q;
    assign fcnt_nx   = vs_edge ? fcnt_q + FCW'(1) : fcnt_q;
    assign mv_nx     = mv_q | (vs_edge & seen_vs);

    // Measurements travel as next-state values so they land at the output
    // with the same DLY latency as the event that produced them.
    assign pay_in = {x_tag, y_tag, sof_tag, s1_data, width_nx, height_nx, fcnt_nx, mv_nx};

    video_delay_line #(
        .STAGES   (DLY - 1),
        .PW       (PW),
        .SYNC_RST (SYNC_IDLE)
    ) u_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .la_de    (bus.i_de),
        .sync_in  (s1_sync),
        .pay_in   (pay_in),
        .sync_out (sync_out),
        .pay_out  (pay_out),
        .eol      (bus.o_eol)
    );

    assign bus.o_hs = sync_out.hs;
    assign bus.o_vs = sync_out.vs;
    assign bus.o_de = sync_out.de;
    assign {bus.x, bus.y, bus.o_sof, bus.o_data, bus.o_width, bus.o_height,
            bus.o_frame_cnt, bus.o_meas_valid} = pay_out;
endmodule

// File: tb/tb_video_pos_gen.sv
// Directed bench for video_pos_gen. Three instances share one stimulus:
//   u0 : defaults (DLY=2, active-high VS)
//   u1 : VS_POL=0, fed the inverted vs
//   u2 : XW=4, for x/width saturation
module tb_video_pos_gen;
    import video_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs    = 1'b0;
    logic        vs    = 1'b0;
    logic        de    = 1'b0;
    logic [23:0] data  = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    video_pos_gen_if #(.XW(12), .YW(12), .DW(24), .FCW(16)) b0 ();
    video_pos_gen_if #(.XW(12), .YW(12), .DW(24), .FCW(16)) b1 ();
    video_pos_gen_if #(.XW(4),  .YW(12), .DW(24), .FCW(16)) b2 ();

    assign b0.i_hs = hs;  assign b0.i_vs = vs;  assign b0.i_de = de;  assign b0.i_data = data;
    assign b1.i_hs = hs;  assign b1.i_vs = ~vs; assign b1.i_de = de;  assign b1.i_data = data;
    assign b2.i_hs = hs;  assign b2.i_vs = vs;  assign b2.i_de = de;  assign b2.i_data = data;

    video_pos_gen #(.XW(12), .YW(12), .DW(24), .DLY(2), .VS_POL(POL_HIGH), .HS_POL(POL_HIGH), .FCW(16))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    video_pos_gen #(.XW(12), .YW(12), .DW(24), .DLY(2), .VS_POL(POL_LOW), .HS_POL(POL_HIGH), .FCW(16))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    video_pos_gen #(.XW(4), .YW(12), .DW(24), .DLY(2), .VS_POL(POL_HIGH), .HS_POL(POL_HIGH), .FCW(16))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One input sample, then step past the capturing edge. With DLY=2 the
    // outputs after this call show the sample driven one call earlier.
    task automatic cyc(input logic h, input logic v, input logic d, input logic [23:0] dat);
        hs = h; vs = v; de = d; data = dat;
        @(posedge clk); #1;
    endtask

    // n active pixels then two blank cycles (hs pulses on the first blank).
    task automatic line(input int n, input int yl, input logic sof1, input logic [7:0] id);
        for (int c = 0; c < n + 2; c++) begin
            cyc(c == n, 1'b0, c < n, (c < n) ? {id, 16'(c)} : 24'h0);
            if (c >= 1 && c <= n) begin
                chk("de",    b0.o_de,   1);
                chk("x",     b0.x,      c - 1);
                chk("y",     b0.y,      yl);
                chk("eol",   b0.o_eol,  c == n);
                chk("sof",   b0.o_sof,  sof1 && c == 1);
                chk("data",  b0.o_data, {id, 16'(c - 1)});
                chk("y_l",   b1.y,      yl);
                chk("sof_l", b1.o_sof,  sof1 && c == 1);
                chk("x_sat", b2.x,      (c - 1 > 15) ? 15 : c - 1);
            end
        end
        chk("de_off",    b0.o_de,    0);
        chk("x_off",     b0.x,       0);
        chk("eol_off",   b0.o_eol,   0);
        chk("hs",        b0.o_hs,    1);
        chk("width",     b0.o_width, n);
        chk("width_sat", b2.o_width, (n > 15) ? 15 : n);
    endtask

    task automatic vsync();
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        chk("vs",       b0.o_vs, 1);
        chk("vs_l",     b1.o_vs, 0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        chk("vs_off",   b0.o_vs, 0);
        chk("vs_off_l", b1.o_vs, 1);
    endtask

    task automatic meas(input int fc, input logic mv, input int h);
        chk("frame_cnt",  b0.o_frame_cnt,  fc);
        chk("meas_valid", b0.o_meas_valid, mv);
        chk("height",     b0.o_height,     h);
        chk("height_l",   b1.o_height,     h);
        chk("fc_l",       b1.o_frame_cnt,  fc);
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_hs"},  b0.o_hs,         0);
        chk({tag, "_vs"},  b0.o_vs,         0);
        chk({tag, "_vsl"}, b1.o_vs,         1);
        chk({tag, "_de"},  b0.o_de,         0);
        chk({tag, "_dat"}, b0.o_data,       0);
        chk({tag, "_x"},   b0.x,            0);
        chk({tag, "_y"},   b0.y,            0);
        chk({tag, "_sof"}, b0.o_sof,        0);
        chk({tag, "_eol"}, b0.o_eol,        0);
        chk({tag, "_w"},   b0.o_width,      0);
        chk({tag, "_h"},   b0.o_height,     0);
        chk({tag, "_fc"},  b0.o_frame_cnt,  0);
        chk({tag, "_mv"},  b0.o_meas_valid, 0);
    endtask

    initial begin
        #12;
        rst_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // frame A: first VS edge opens the frame, nothing measured yet
        vsync();
        meas(1, 1'b0, 0);
        line(4, 0, 1'b1, 8'h10);
        line(4, 1, 1'b0, 8'h11);
        line(4, 2, 1'b0, 8'h12);

        // second VS edge bounds frame A
        vsync();
        meas(2, 1'b1, 3);
        chk("width_f", b0.o_width, 4);
        line(4, 0, 1'b1, 8'h20);
        line(4, 1, 1'b0, 8'h21);
        line(4, 2, 1'b0, 8'h22);

        // frame C: single-pixel first line, then a 20-pixel line
        vsync();
        meas(3, 1'b1, 3);
        line(1,  0, 1'b1, 8'h30);
        line(20, 1, 1'b0, 8'h31);
        line(4,  2, 1'b0, 8'h32);

        vsync();
        meas(4, 1'b1, 3);
        line(4, 0, 1'b1, 8'h40);

        // asynchronous reset in the middle of an active line
        cyc(1'b0, 1'b0, 1'b1, 24'h4100);
        cyc(1'b0, 1'b0, 1'b1, 24'h4101);
        chk("pre_rst_de", b0.o_de, 1);
        #2 rst_n = 1'b0;
        #1;
        rst_vals("mid");
        hs = 1'b0; vs = 1'b0; de = 1'b0; data = '0;
        @(negedge clk);
        rst_n = 1'b1;

        vsync();
        meas(1, 1'b0, 0);
        line(4, 0, 1'b1, 8'h50);
        line(4, 1, 1'b0, 8'h51);
        vsync();
        meas(2, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
